gp3io_mux_switch_ctrl: RTL and testbench

Break-before-make sequencer for the GP3IO mux select fields. It sits between the mux's AXI4-Lite register file and the mux datapath. Each write to a port-select register becomes a one-word request. For each accepted change the block blanks the target port to its safe idle level, swaps the select field, holds the blank while the new source settles, then releases it. Only one port switches at a time, so no GPIO pin is ever driven by two sources or glitched mid-switch.

---
 rtl/gp3io_mux_switch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gp3io_mux_switch_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp3io_mux_switch_ctrl.sv
// -----------------------------------------------------------------------------
// gp3io_mux_switch_ctrl
//
// Break-before-make sequencer for the GP3IO mux select fields. Each accepted
// request blanks its target port, holds the blank for D cycles, swaps the
// select field, holds the blank for another D cycles while the new source
// settles, then releases it. Only one port switches at a time.
//
// Ports:
//   ACLK        clock, rising edge
//   ARESETN     synchronous active-low reset
//   req_valid   switch request valid
//   req_ready   block can accept a request (registered)
//   req_port    target port index (values >= NUM_PORTS are rejected)
//   req_sel     new source select for req_port
//   cfg_dead    dead time in cycles (0 is treated as 1), sampled at acceptance
//   sel_out     packed select fields, port p at [p*SEL_WIDTH +: SEL_WIDTH]
//   port_blank  per-port force-to-idle
//   busy        a switch sequence is in progress
//   done        one-cycle pulse when a request completes
//   err         one-cycle pulse, with done, for an out-of-range port
// -----------------------------------------------------------------------------
module gp3io_mux_switch_ctrl #(
    parameter int NUM_PORTS = 4,
    parameter int SEL_WIDTH = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [3:0]                     req_port,
    input  logic [SEL_WIDTH-1:0]           req_sel,
    input  logic [CNT_WIDTH-1:0]           cfg_dead,
    output logic [NUM_PORTS*SEL_WIDTH-1:0] sel_out,
    output logic [NUM_PORTS-1:0]           port_blank,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BLANK  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    localparam logic [4:0]           PORT_LIMIT = 5'(NUM_PORTS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic [1:0]           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] dead_q;
    logic [3:0]           port_q;
    logic [SEL_WIDTH-1:0] new_sel_q;
    logic [SEL_WIDTH-1:0] sel_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] blank_q;

    logic                 accept;
    logic                 port_ok;
    logic [SEL_WIDTH-1:0] cur_sel;
    logic [CNT_WIDTH-1:0] dead_eff;

    assign accept   = req_valid && req_ready;
    assign port_ok  = {1'b0, req_port} < PORT_LIMIT;
    // A zero dead time still gets one cycle per phase so the blank is never skipped.
    assign dead_eff = (cfg_dead == '0) ? CNT_ONE : cfg_dead;

    // Current field of the requested port; only meaningful when port_ok.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_port == 4'(p)) cur_sel = sel_q[p];
        end
    end

    always_comb begin
        sel_out = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_out[p*SEL_WIDTH +: SEL_WIDTH] = sel_q[p];
        end
    end

    assign port_blank = blank_q;
    assign busy       = (state_q != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dead_q    <= '0;
            port_q    <= '0;
            new_sel_q <= '0;
            blank_q   <= '0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            // NOTE: the select array drives the mux directly, so it must be
            // reset like any control register rather than left as storage.
            for (int p = 0; p < NUM_PORTS; p++) sel_q[p] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        if (!port_ok) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (cur_sel == req_sel) begin
                            done <= 1'b1;
                        end else begin
                            state_q   <= BLANK;
                            port_q    <= req_port;
                            new_sel_q <= req_sel;
                            dead_q    <= dead_eff;
                            cnt_q     <= dead_eff;
                            req_ready <= 1'b0;
                            for (int p = 0; p < NUM_PORTS; p++) begin
                                if (req_port == 4'(p)) blank_q[p] <= 1'b1;
                            end
                        end
                    end
                end

                BLANK: begin
                    // The edge that would take the counter to zero is the swap edge.
                    if (cnt_q <= CNT_ONE) begin
                        state_q <= SETTLE;
                        cnt_q   <= dead_q;
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (port_q == 4'(p)) sel_q[p] <= new_sel_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                SETTLE: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (port_q == 4'(p)) blank_q[p] <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    blank_q   <= '0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gp3io_mux_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gp3io_mux_switch_ctrl
//
// Self-checking bench for gp3io_mux_switch_ctrl (NUM_PORTS=4, SEL_WIDTH=2,
// CNT_WIDTH=8). A small model of the select fields predicts each request's
// outcome; predictions go into a queue when a request is driven and are
// popped when done is seen. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gp3io_mux_switch_ctrl;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_port;
    logic [1:0] req_sel;
    logic [7:0] cfg_dead;
    logic [7:0] sel_out;
    logic [3:0] port_blank;
    logic       busy;
    logic       done;
    logic       err;

    gp3io_mux_switch_ctrl #(
        .NUM_PORTS(4),
        .SEL_WIDTH(2),
        .CNT_WIDTH(8)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_port  (req_port),
        .req_sel   (req_sel),
        .cfg_dead  (cfg_dead),
        .sel_out   (sel_out),
        .port_blank(port_blank),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial forever #5 ACLK = ~ACLK;

    typedef struct {
        logic       err;
        logic [7:0] sel;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] model_sel [4];
    int         total = 0;
    int         bad   = 0;

    function automatic logic [7:0] pack_model();
        logic [7:0] v;
        v = '0;
        for (int p = 0; p < 4; p++) v[p*2 +: 2] = model_sel[p];
        return v;
    endfunction

    task automatic pop_check(input string name, input int lat);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: done seen with empty scoreboard", name);
        end else begin
            e = exp_q.pop_front();
            if ({err, sel_out} !== {e.err, e.sel} || lat != e.lat) begin
                bad++;
                $display("FAIL %s: err=%b sel_out=%h lat=%0d, want err=%b sel_out=%h lat=%0d",
                         name, err, sel_out, lat, e.err, e.sel, e.lat);
            end
        end
    endtask

    // Drives one request from a falling edge, follows it to done and returns
    // on the falling edge after the done pulse.
    task automatic do_req(input string name, input logic [3:0] port,
                          input logic [1:0] sel, input logic [7:0] dead);
        bit         inval, sw, seen;
        int         d;
        logic [7:0] old_s, new_s;
        logic [3:0] mask;
        exp_t       e;
        inval = (port >= 4);
        sw    = !inval && (model_sel[port[1:0]] != sel);
        d     = (dead == 0) ? 1 : int'(dead);
        old_s = pack_model();
        mask  = sw ? (4'b0001 << port) : 4'b0000;
        if (sw) model_sel[port[1:0]] = sel;
        new_s = pack_model();
        e.err = inval;
        e.sel = new_s;
        e.lat = sw ? 2 * d : 0;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: req_ready=%b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_port  = port;
        req_sel   = sel;
        cfg_dead  = dead;
        exp_q.push_back(e);
        @(negedge ACLK);
        req_valid = 1'b0;
        req_port  = 4'($urandom);
        req_sel   = 2'($urandom);
        cfg_dead  = 8'($urandom);
        seen = 0;
        for (int k = 0; k <= 2 * 256 + 4; k++) begin
            logic [3:0] xb;
            logic [7:0] xs;
            logic       xbusy;
            xb    = (sw && k < 2 * d) ? mask : 4'b0000;
            xs    = (sw && k < d) ? old_s : new_s;
            xbusy = sw && k < 2 * d;
            total++;
            if ({port_blank, sel_out, busy, req_ready} !== {xb, xs, xbusy, ~xbusy}) begin
                bad++;
                $display("FAIL %s_k%0d: blank=%b sel_out=%h busy=%b ready=%b, want blank=%b sel_out=%h busy=%b ready=%b",
                         name, k, port_blank, sel_out, busy, req_ready, xb, xs, xbusy, ~xbusy);
            end
            if (done === 1'b1) begin
                pop_check(name, k);
                seen = 1;
                break;
            end
            @(negedge ACLK);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done pulse, want one after %0d cycles", name, e.lat);
            void'(exp_q.pop_front());
        end
        @(negedge ACLK);
        total++;
        if ({done, err} !== 2'b00) begin
            bad++;
            $display("FAIL %s_pulse: done=%b err=%b one cycle later, want 0 0", name, done, err);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'($urandom);
            req_port  = 4'($urandom);
            req_sel   = 2'($urandom);
            cfg_dead  = 8'($urandom);
            @(negedge ACLK);
            if (i >= 1) begin
                total++;
                if ({sel_out, port_blank, done, err, busy, req_ready} !== 16'h0) begin
                    bad++;
                    $display("FAIL reset_%0d: sel_out=%h blank=%b done=%b err=%b busy=%b ready=%b, want all 0",
                             i, sel_out, port_blank, done, err, busy, req_ready);
                end
            end
        end
        req_valid = 1'b0;
        ARESETN   = 1'b1;
        @(negedge ACLK);
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: req_ready=%b busy=%b, want 1 0", req_ready, busy);
        end
        for (int p = 0; p < 4; p++) model_sel[p] = 2'd0;
    endtask

    task automatic test_switch();
        do_req("switch", 4'd2, 2'd3, 8'd4);
    endtask

    task automatic test_noop();
        do_req("noop", 4'd2, 2'd3, 8'd9);
    endtask

    task automatic test_zero_dead();
        do_req("zero_dead", 4'd0, 2'd1, 8'd0);
    endtask

    task automatic test_invalid();
        do_req("invalid", 4'd5, 2'd2, 8'd3);
    endtask

    task automatic test_max_dead();
        do_req("max_dead", 4'd1, 2'd2, 8'd255);
    endtask

    // Invalid then no-op accepted on consecutive edges.
    task automatic test_back_to_back();
        exp_t e;
        req_valid = 1'b1;
        req_port  = 4'd9;
        req_sel   = 2'd1;
        cfg_dead  = 8'd5;
        e.err = 1'b1; e.sel = pack_model(); e.lat = 0;
        exp_q.push_back(e);
        @(negedge ACLK);
        total++;
        if ({done, req_ready} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_first: done=%b ready=%b, want 1 1", done, req_ready);
        end else begin
            pop_check("b2b_first", 0);
        end
        req_port = 4'd2;
        req_sel  = model_sel[2];
        e.err = 1'b0; e.sel = pack_model(); e.lat = 0;
        exp_q.push_back(e);
        @(negedge ACLK);
        req_valid = 1'b0;
        total++;
        if ({done, req_ready, port_blank} !== 6'b110000) begin
            bad++;
            $display("FAIL b2b_second: done=%b ready=%b blank=%b, want 1 1 0000", done, req_ready, port_blank);
        end else begin
            pop_check("b2b_second", 0);
        end
        @(negedge ACLK);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: done=%b, want 0", done);
        end
    endtask

    // A held req_valid during a D=3 switch must next be accepted at E0+7.
    task automatic test_busy_holdoff();
        exp_t e;
        bit   seen;
        req_valid = 1'b1;
        req_port  = 4'd3;
        req_sel   = 2'd2;
        cfg_dead  = 8'd3;
        model_sel[3] = 2'd2;
        e.err = 1'b0; e.sel = pack_model(); e.lat = 6;
        exp_q.push_back(e);
        model_sel[3] = 2'd1;
        e.sel = pack_model();
        exp_q.push_back(e);
        @(negedge ACLK);
        req_sel = 2'd1;
        for (int k = 0; k <= 7; k++) begin
            logic xbusy, xdone;
            xbusy = (k < 6) || (k == 7);
            xdone = (k == 6);
            total++;
            if ({busy, done, req_ready} !== {xbusy, xdone, xdone}) begin
                bad++;
                $display("FAIL holdoff_k%0d: busy=%b done=%b ready=%b, want %b %b %b",
                         k, busy, done, req_ready, xbusy, xdone, xdone);
            end
            if (done === 1'b1) pop_check("holdoff_first", k);
            if (k == 7) req_valid = 1'b0;
            @(negedge ACLK);
        end
        seen = 0;
        for (int k = 8; k <= 40; k++) begin
            if (done === 1'b1) begin
                pop_check("holdoff_second", k - 7);
                seen = 1;
                break;
            end
            @(negedge ACLK);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL holdoff_timeout: second request never completed, want done at E0+13");
            void'(exp_q.pop_front());
        end
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid_blank();
        total++;
        if (sel_out === 8'h00) begin
            bad++;
            $display("FAIL midrst_pre: sel_out=%h, want nonzero before reset", sel_out);
        end
        req_valid = 1'b1;
        req_port  = 4'd1;
        req_sel   = 2'd3;
        cfg_dead  = 8'd10;
        @(negedge ACLK);
        req_valid = 1'b0;
        total++;
        if ({port_blank, busy} !== 5'b00101) begin
            bad++;
            $display("FAIL midrst_blank: blank=%b busy=%b, want 0010 1", port_blank, busy);
        end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            @(negedge ACLK);
            total++;
            if ({sel_out, port_blank, done, err, busy, req_ready} !== 16'h0) begin
                bad++;
                $display("FAIL midrst_k%0d: sel_out=%h blank=%b done=%b err=%b busy=%b ready=%b, want all 0",
                         k, sel_out, port_blank, done, err, busy, req_ready);
            end
        end
        ARESETN = 1'b1;
        for (int p = 0; p < 4; p++) model_sel[p] = 2'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge ACLK);
            total++;
            if ({done, req_ready, sel_out} !== {2'b01, 8'h00}) begin
                bad++;
                $display("FAIL midrst_after_%0d: done=%b ready=%b sel_out=%h, want 0 1 00",
                         k, done, req_ready, sel_out);
            end
        end
    endtask

    initial begin
        ARESETN   = 1'b0;
        req_valid = 1'b0;
        req_port  = '0;
        req_sel   = '0;
        cfg_dead  = '0;
        for (int p = 0; p < 4; p++) model_sel[p] = 2'd0;
        @(negedge ACLK);
        test_reset();
        test_switch();
        test_noop();
        test_zero_dead();
        test_invalid();
        test_back_to_back();
        test_busy_holdoff();
        test_max_dead();
        test_reset_mid_blank();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
